// File: rtl/half_argmin_stream.sv
// rtl/half_argmin_stream.sv - streaming argmin over IEEE-754 half-precision vectors
// One result pulse per vector carrying minimum value, its index, element count-1 and overflow.
module half_argmin_stream #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [15:0]      a,
  output logic             out_valid,
  output logic [15:0]      min_val,
  output logic [IDX_W-1:0] min_idx,
  output logic [IDX_W-1:0] count,
  output logic             ovf
);

  typedef enum logic {IDLE, ACC} state_t;

  state_t           state, state_nxt;
  logic [15:0]      run_min, run_min_nxt;
  logic [IDX_W-1:0] run_idx, run_idx_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;
  logic             ovf_r, ovf_nxt;
  logic             done;

  // Sign-magnitude strict less-than; NaN/Inf are ordered by their raw bits.
  function automatic logic half_lt(input logic [15:0] x, input logic [15:0] y);
    logic r;
    if (x[15] != y[15]) r = x[15];
    else if (x[15])     r = (x[14:0] > y[14:0]);
    else                r = (x[14:0] < y[14:0]);
    return r;
  endfunction

  assign done = in_valid & in_last;

  always_comb begin
    state_nxt   = state;
    run_min_nxt = run_min;
    run_idx_nxt = run_idx;
    cnt_nxt     = cnt;
    ovf_nxt     = ovf_r;
    if (in_valid) begin
      if (state == IDLE) begin
        run_min_nxt = a;
        run_idx_nxt = '0;
        cnt_nxt     = '0;
        ovf_nxt     = 1'b0;
        state_nxt   = in_last ? IDLE : ACC;
      end else begin
        cnt_nxt = cnt + IDX_W'(1);
        if (&cnt) ovf_nxt = 1'b1;
        // Strict compare keeps the earliest index on ties.
        if (half_lt(a, run_min)) begin
          run_min_nxt = a;
          run_idx_nxt = cnt_nxt;
        end
        if (in_last) state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      run_min <= '0;
      run_idx <= '0;
      cnt     <= '0;
      ovf_r   <= 1'b0;
    end else begin
      state   <= state_nxt;
      run_min <= run_min_nxt;
      run_idx <= run_idx_nxt;
      cnt     <= cnt_nxt;
      ovf_r   <= ovf_nxt;
    end
  end

  // Result registers move only on the closing sample so they hold between pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      min_val   <= '0;
      min_idx   <= '0;
      count     <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= done;
      if (done) begin
        min_val <= run_min_nxt;
        min_idx <= run_idx_nxt;
        count   <= cnt_nxt;
        ovf     <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_half_argmin_stream.sv
// tb/tb_half_argmin_stream.sv - directed table-driven bench for half_argmin_stream
// Drives an IDX_W=8 and an IDX_W=2 instance from shared stimulus.
module tb_half_argmin_stream;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [15:0] a = '0;

  logic        ov8, ovf8;
  logic [15:0] min8;
  logic [7:0]  idx8, cnt8;
  logic        ov2, ovf2;
  logic [15:0] min2;
  logic [1:0]  idx2, cnt2;

  int errors = 0;
  int checks = 0;

  half_argmin_stream #(.IDX_W(8)) dut8 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_last(in_last), .a(a),
    .out_valid(ov8), .min_val(min8), .min_idx(idx8), .count(cnt8), .ovf(ovf8)
  );

  half_argmin_stream #(.IDX_W(2)) dut2 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_last(in_last), .a(a),
    .out_valid(ov2), .min_val(min2), .min_idx(idx2), .count(cnt2), .ovf(ovf2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        l;
    logic [15:0] d;
    logic        ev;
    logic [15:0] emin;
    logic [7:0]  eidx;
    logic [7:0]  ecnt;
    logic        eovf;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk8(input string n, input logic ev, input logic [15:0] emin,
                      input logic [7:0] eidx, input logic [7:0] ecnt, input logic eovf);
    chk({n, ".out_valid"}, {31'd0, ov8}, {31'd0, ev});
    chk({n, ".min_val"}, {16'd0, min8}, {16'd0, emin});
    chk({n, ".min_idx"}, {24'd0, idx8}, {24'd0, eidx});
    chk({n, ".count"}, {24'd0, cnt8}, {24'd0, ecnt});
    chk({n, ".ovf"}, {31'd0, ovf8}, {31'd0, eovf});
  endtask

  task automatic chk2(input string n, input logic ev, input logic [15:0] emin,
                      input logic [1:0] eidx, input logic [1:0] ecnt, input logic eovf);
    chk({n, ".w2.out_valid"}, {31'd0, ov2}, {31'd0, ev});
    chk({n, ".w2.min_val"}, {16'd0, min2}, {16'd0, emin});
    chk({n, ".w2.min_idx"}, {30'd0, idx2}, {30'd0, eidx});
    chk({n, ".w2.count"}, {30'd0, cnt2}, {30'd0, ecnt});
    chk({n, ".w2.ovf"}, {31'd0, ovf2}, {31'd0, eovf});
  endtask

  task automatic step(input logic v, input logic l, input logic [15:0] d);
    @(negedge clk);
    in_valid = v;
    in_last  = l;
    a        = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Expected outputs are observed just after the edge that samples each row.
    tbl[0]  = '{1'b1, 1'b0, 16'h3C00, 1'b0, 16'h0000, 8'd0, 8'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 16'h3800, 1'b0, 16'h0000, 8'd0, 8'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 16'h4000, 1'b0, 16'h0000, 8'd0, 8'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 16'h3800, 1'b1, 16'h3800, 8'd1, 8'd3, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h3800, 8'd1, 8'd3, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h3800, 8'd1, 8'd3, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 16'h8000, 1'b0, 16'h3800, 8'd1, 8'd3, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 16'hC000, 1'b0, 16'h3800, 8'd1, 8'd3, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 16'hBC00, 1'b1, 16'hC000, 8'd2, 8'd3, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 16'h7BFF, 1'b1, 16'h7BFF, 8'd0, 8'd0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 16'h3C00, 1'b0, 16'h7BFF, 8'd0, 8'd0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 16'h3400, 1'b1, 16'h3400, 8'd1, 8'd1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 16'h4400, 1'b0, 16'h3400, 8'd1, 8'd1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h3400, 8'd1, 8'd1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 16'h8000, 1'b0, 16'h3400, 8'd1, 8'd1, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 16'h4200, 1'b1, 16'h4200, 8'd1, 8'd1, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 16'hBC00, 1'b0, 16'h4200, 8'd1, 8'd1, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 16'hBC00, 1'b1, 16'hBC00, 8'd0, 8'd1, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'hBC00, 8'd0, 8'd1, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 16'h8000, 1'b1, 16'h8000, 8'd1, 8'd1, 1'b0};
    tbl[20] = '{1'b1, 1'b0, 16'h7C00, 1'b0, 16'h8000, 8'd1, 8'd1, 1'b0};
    tbl[21] = '{1'b1, 1'b1, 16'hFC00, 1'b1, 16'hFC00, 8'd1, 8'd1, 1'b0};

    #2 rstn = 1'b0;
    #1;
    chk8("reset", 1'b0, 16'h0000, 8'd0, 8'd0, 1'b0);
    chk2("reset", 1'b0, 16'h0000, 2'd0, 2'd0, 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].v, tbl[i].l, tbl[i].d);
      chk8($sformatf("row%0d", i), tbl[i].ev, tbl[i].emin, tbl[i].eidx, tbl[i].ecnt, tbl[i].eovf);
    end

    // Index/count wrap on the narrow instance; wide one sees plain five elements.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 16'h4000);
      chk({$sformatf("wrap%0d", i), ".out_valid"}, {30'd0, ov2, ov8}, 32'd0);
    end
    step(1'b1, 1'b1, 16'h3C00);
    chk2("wrap", 1'b1, 16'h3C00, 2'd0, 2'd0, 1'b1);
    chk8("wrap", 1'b1, 16'h3C00, 8'd4, 8'd4, 1'b0);

    step(1'b1, 1'b1, 16'h3C00);
    chk2("ovf_clear", 1'b1, 16'h3C00, 2'd0, 2'd0, 1'b0);
    step(1'b0, 1'b0, 16'h0000);
    chk2("pulse_once", 1'b0, 16'h3C00, 2'd0, 2'd0, 1'b0);

    // Reset mid-vector: immediate clear, partial vector dropped.
    step(1'b1, 1'b0, 16'h4400);
    step(1'b1, 1'b0, 16'h4200);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    rstn     = 1'b0;
    #1;
    chk8("midrst", 1'b0, 16'h0000, 8'd0, 8'd0, 1'b0);
    chk2("midrst", 1'b0, 16'h0000, 2'd0, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    chk("midrst_hold.out_valid", {30'd0, ov2, ov8}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step(1'b0, 1'b0, 16'h0000);
    chk("post_rst_idle.out_valid", {30'd0, ov2, ov8}, 32'd0);
    step(1'b1, 1'b1, 16'hBC00);
    chk8("post_rst", 1'b1, 16'hBC00, 8'd0, 8'd0, 1'b0);
    chk2("post_rst", 1'b1, 16'hBC00, 2'd0, 2'd0, 1'b0);
    step(1'b0, 1'b0, 16'h0000);
    chk8("post_rst_hold", 1'b0, 16'hBC00, 8'd0, 8'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
